// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K-and-S processor datapath and controller.
// Holds the decoded-instruction enum, opcode values, ALU op codes and widths.
package k_and_s_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 4;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_BRANCH = 4'd1,
    I_BZERO  = 4'd2,
    I_BNZERO = 4'd3,
    I_BNEG   = 4'd4,
    I_BNNEG  = 4'd5,
    I_BOV    = 4'd6,
    I_BNOV   = 4'd7,
    I_LOAD   = 4'd8,
    I_STORE  = 4'd9,
    I_MOVE   = 4'd10,
    I_ADD    = 4'd11,
    I_SUB    = 4'd12,
    I_AND    = 4'd13,
    I_OR     = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNZERO = 8'h03;
  localparam logic [7:0] OP_BNEG   = 8'h04;
  localparam logic [7:0] OP_BNNEG  = 8'h05;
  localparam logic [7:0] OP_BOV    = 8'h06;
  localparam logic [7:0] OP_BNOV   = 8'h07;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

endpackage

// File: rtl/data_path_alu.sv
// Combinational 16-bit ALU: OR / ADD / SUB / AND on A op B, plus the
// zero, negative, unsigned-overflow (carry/borrow) and signed-overflow flags.
module alu
  import k_and_s_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        operation,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              unsigned_overflow,
  output logic              signed_overflow
);

  logic [DATA_W:0] wide;

  // Result and flags; the extra top bit of 'wide' is carry on ADD, borrow on SUB.
  always_comb begin
    wide              = '0;
    result            = '0;
    unsigned_overflow = 1'b0;
    signed_overflow   = 1'b0;
    case (operation)
      ALU_ADD: begin
        wide              = {1'b0, a} + {1'b0, b};
        result            = wide[DATA_W-1:0];
        unsigned_overflow = wide[DATA_W];
        signed_overflow   = (a[DATA_W-1] == b[DATA_W-1]) &&
                            (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        wide              = {1'b0, a} - {1'b0, b};
        result            = wide[DATA_W-1:0];
        unsigned_overflow = wide[DATA_W];
        signed_overflow   = (a[DATA_W-1] != b[DATA_W-1]) &&
                            (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      default: result = a | b;
    endcase
    zero = (result == '0);
    neg  = result[DATA_W-1];
  end

endmodule

// File: rtl/data_path.sv
// K-and-S datapath: PC, IR, 4x16 register file, ALU and flags register.
// Decodes the IR for the controller and drives the 32-word RAM address/data.
// Build option: define DATA_PATH_TRAP_ILLEGAL_EN to decode unknown opcodes
// as I_HALT instead of I_NOP.
module data_path
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  input  logic [DATA_W-1:0]       data_in,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out
);

`ifdef DATA_PATH_TRAP_ILLEGAL_EN
  localparam decoded_instruction_type ILLEGAL_DECODE = I_HALT;
`else
  localparam decoded_instruction_type ILLEGAL_DECODE = I_NOP;
`endif

  logic [ADDR_W-1:0]    pc;
  logic [DATA_W-1:0]    ir;
  logic [DATA_W-1:0]    regs [NUM_REGS];
  logic [REG_IDX_W-1:0] sel_a;
  logic [REG_IDX_W-1:0] sel_b;
  logic [REG_IDX_W-1:0] sel_c;
  logic [DATA_W-1:0]    reg_a;
  logic [DATA_W-1:0]    reg_b;
  logic [DATA_W-1:0]    alu_result;
  logic [DATA_W-1:0]    write_data;
  logic                 alu_zero;
  logic                 alu_neg;
  logic                 alu_uov;
  logic                 alu_sov;

  // IR bit 7 is not a field in any instruction format.
  logic unused_ir_bit;
  assign unused_ir_bit = ir[7];

  // PC: branch target from the IR address field, otherwise increment (wraps 31->0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (pc_enable) begin
      pc <= branch ? ir[ADDR_W-1:0] : pc + 5'd1;
    end
  end

  // IR: captures the RAM word addressed by the current (pre-increment) PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (ir_enable) begin
      ir <= data_in;
    end
  end

  // Opcode decode; unknown opcodes fall to the build-selected default.
  always_comb begin
    decoded_instruction = ILLEGAL_DECODE;
    case (ir[15:8])
      OP_NOP:    decoded_instruction = I_NOP;
      OP_BRANCH: decoded_instruction = I_BRANCH;
      OP_BZERO:  decoded_instruction = I_BZERO;
      OP_BNZERO: decoded_instruction = I_BNZERO;
      OP_BNEG:   decoded_instruction = I_BNEG;
      OP_BNNEG:  decoded_instruction = I_BNNEG;
      OP_BOV:    decoded_instruction = I_BOV;
      OP_BNOV:   decoded_instruction = I_BNOV;
      OP_LOAD:   decoded_instruction = I_LOAD;
      OP_STORE:  decoded_instruction = I_STORE;
      OP_MOVE:   decoded_instruction = I_MOVE;
      OP_ADD:    decoded_instruction = I_ADD;
      OP_SUB:    decoded_instruction = I_SUB;
      OP_AND:    decoded_instruction = I_AND;
      OP_OR:     decoded_instruction = I_OR;
      OP_HALT:   decoded_instruction = I_HALT;
      default:   decoded_instruction = ILLEGAL_DECODE;
    endcase
  end

  // Register-index fields; LOAD/STORE move their register to IR[6:5], MOVE reads A twice.
  always_comb begin
    sel_a = ir[3:2];
    sel_b = ir[1:0];
    sel_c = ir[5:4];
    case (decoded_instruction)
      I_LOAD:  sel_c = ir[6:5];
      I_STORE: sel_a = ir[6:5];
      I_MOVE:  sel_b = ir[3:2];
      default: ;
    endcase
  end

  assign reg_a = regs[sel_a];
  assign reg_b = regs[sel_b];

  alu u_alu (
    .a                 (reg_a),
    .b                 (reg_b),
    .operation         (operation),
    .result            (alu_result),
    .zero              (alu_zero),
    .neg               (alu_neg),
    .unsigned_overflow (alu_uov),
    .signed_overflow   (alu_sov)
  );

  assign write_data = c_sel ? alu_result : data_in;

  // Register file write port C; reads are combinational so same-cycle reads see the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_reg_enable) begin
      regs[sel_c] <= write_data;
    end
  end

  // Flags register: all four ALU flags load together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_op           <= alu_zero;
      neg_op            <= alu_neg;
      unsigned_overflow <= alu_uov;
      signed_overflow   <= alu_sov;
    end
  end

  assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;
  assign data_out = reg_a;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path with a scoreboard queue of expected observations.
module tb_data_path;
  import k_and_s_pkg::*;

`ifdef DATA_PATH_TRAP_ILLEGAL_EN
  localparam decoded_instruction_type ILL = I_HALT;
`else
  localparam decoded_instruction_type ILL = I_NOP;
`endif

  localparam int OBS_ADDR  = 0;
  localparam int OBS_DOUT  = 1;
  localparam int OBS_DEC   = 2;
  localparam int OBS_FLAGS = 3;

  logic clk, rst_n, branch, pc_enable, ir_enable, write_reg_enable;
  logic addr_sel, c_sel, flags_reg_enable;
  logic [1:0] operation;
  logic [15:0] data_in, data_out;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic [4:0] ram_addr;

  typedef struct {
    string       tag;
    int          obs;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [4:0] pc_m = 5'd0;

  logic [7:0] op_tab [19] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                              8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF,
                              8'h55, 8'h08, 8'hA5};
  decoded_instruction_type dec_tab [19] = '{I_NOP, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                              I_BNNEG, I_BOV, I_BNOV, I_LOAD, I_STORE, I_MOVE, I_ADD,
                              I_SUB, I_AND, I_OR, I_HALT, ILL, ILL, ILL};

  data_path dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .write_reg_enable    (write_reg_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .flags_reg_enable    (flags_reg_enable),
    .data_in             (data_in),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .ram_addr            (ram_addr),
    .data_out            (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag, input int obs, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.obs = obs;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.obs)
        OBS_ADDR: got = {11'b0, ram_addr};
        OBS_DOUT: got = data_out;
        OBS_DEC:  got = {12'b0, decoded_instruction};
        default:  got = {12'b0, zero_op, neg_op, unsigned_overflow, signed_overflow};
      endcase
      total++;
      assert (got === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic idle();
    branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
    c_sel = 0; flags_reg_enable = 0; operation = ALU_OR;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] word);
    idle();
    data_in = word;
    ir_enable = 1;
    pc_enable = 1;
    tick();
    idle();
    pc_m = pc_m + 5'd1;
  endtask

  task automatic alu_step(input logic [1:0] op, input logic wr, input logic fl);
    operation = op;
    c_sel = 1;
    write_reg_enable = wr;
    flags_reg_enable = fl;
    tick();
    idle();
  endtask

  initial begin
    idle();
    addr_sel = 0;
    data_in = 16'h0000;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    push_exp("rst_addr", OBS_ADDR, 16'h0000);
    push_exp("rst_dout", OBS_DOUT, 16'h0000);
    push_exp("rst_dec", OBS_DEC, 16'(I_NOP));
    push_exp("rst_flags", OBS_FLAGS, 16'h0000);
    drain();
    repeat (3) tick();
    push_exp("hold_addr", OBS_ADDR, 16'h0000);
    push_exp("hold_flags", OBS_FLAGS, 16'h0000);
    push_exp("hold_dec", OBS_DEC, 16'(I_NOP));
    drain();

    fetch(16'hA11B);
    push_exp("fetch_dec", OBS_DEC, 16'(I_ADD));
    push_exp("fetch_pc", OBS_ADDR, 16'd1);
    drain();
    addr_sel = 1; #1;
    push_exp("fetch_irfield", OBS_ADDR, 16'h001B);
    drain();

    fetch(16'h8145);
    push_exp("load_dec", OBS_DEC, 16'(I_LOAD));
    push_exp("load_addr", OBS_ADDR, 16'h0005);
    drain();
    addr_sel = 0;
    data_in = 16'h7FFF; c_sel = 0; write_reg_enable = 1;
    tick(); idle();
    fetch(16'h8240);
    push_exp("store_dec", OBS_DEC, 16'(I_STORE));
    push_exp("r2_load", OBS_DOUT, 16'h7FFF);
    push_exp("pc_3", OBS_ADDR, 16'(pc_m));
    drain();

    fetch(16'h8166);
    data_in = 16'h0001; write_reg_enable = 1;
    tick(); idle();

    fetch(16'hA115);
    data_in = 16'h00AA; write_reg_enable = 1; #1;
    push_exp("rw_old", OBS_DOUT, 16'h0000);
    drain();
    tick(); idle();
    push_exp("rw_new", OBS_DOUT, 16'h00AA);
    drain();

    fetch(16'hA11B);
    write_reg_enable = 1; flags_reg_enable = 1; c_sel = 1; operation = ALU_ADD; #1;
    push_exp("add_flags_pre", OBS_FLAGS, 16'h0000);
    drain();
    alu_step(ALU_ADD, 1, 1);
    push_exp("add_flags", OBS_FLAGS, 16'b0101);
    drain();
    fetch(16'h8220);
    push_exp("add_result", OBS_DOUT, 16'h8000);
    drain();

    fetch(16'hA203);
    alu_step(ALU_SUB, 1, 1);
    push_exp("sub_flags", OBS_FLAGS, 16'b0110);
    drain();
    fetch(16'h8200);
    push_exp("sub_result", OBS_DOUT, 16'hFFFF);
    drain();

    fetch(16'hA304);
    alu_step(ALU_AND, 0, 1);
    push_exp("and_flags", OBS_FLAGS, 16'b0100);
    drain();
    fetch(16'hA103);
    alu_step(ALU_ADD, 0, 1);
    push_exp("add_carry_flags", OBS_FLAGS, 16'b1010);
    drain();
    fetch(16'hA207);
    alu_step(ALU_SUB, 0, 1);
    push_exp("sub_sov_flags", OBS_FLAGS, 16'b0001);
    drain();
    repeat (3) tick();
    push_exp("flags_hold", OBS_FLAGS, 16'b0001);
    push_exp("pc_hold", OBS_ADDR, 16'(pc_m));
    drain();

    fetch(16'h9134);
    push_exp("move_dec", OBS_DEC, 16'(I_MOVE));
    drain();
    alu_step(ALU_OR, 1, 0);
    fetch(16'h8260);
    push_exp("move_result", OBS_DOUT, 16'h8000);
    drain();

    for (int i = 0; i < 19; i++) begin
      fetch({op_tab[i], 8'h00});
      push_exp($sformatf("dec_%02h", op_tab[i]), OBS_DEC, 16'(dec_tab[i]));
      drain();
    end
    push_exp("pc_wrap_fetch", OBS_ADDR, 16'(pc_m));
    drain();

    fetch(16'h011F);
    push_exp("branch_dec", OBS_DEC, 16'(I_BRANCH));
    drain();
    branch = 1; pc_enable = 1;
    tick(); idle();
    push_exp("branch_pc31", OBS_ADDR, 16'd31);
    drain();
    pc_enable = 1;
    tick(); idle();
    push_exp("branch_wrap0", OBS_ADDR, 16'd0);
    drain();
    pc_m = 5'd0;

    fetch(16'h8220);
    push_exp("pre_rst_dout", OBS_DOUT, 16'h8000);
    drain();
    data_in = 16'h1234; c_sel = 0; write_reg_enable = 1; flags_reg_enable = 1; pc_enable = 1;
    #3 rst_n = 0;
    #1;
    push_exp("arst_addr", OBS_ADDR, 16'h0000);
    push_exp("arst_dout", OBS_DOUT, 16'h0000);
    push_exp("arst_dec", OBS_DEC, 16'(I_NOP));
    push_exp("arst_flags", OBS_FLAGS, 16'h0000);
    drain();
    idle();
    @(posedge clk);
    #2 rst_n = 1;
    pc_m = 5'd0;
    fetch(16'h8240);
    push_exp("arst_r2", OBS_DOUT, 16'h0000);
    drain();
    fetch(16'h8220);
    push_exp("arst_r1", OBS_DOUT, 16'h0000);
    push_exp("arst_pc", OBS_ADDR, 16'd2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
